// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined multiply unit: op encodings, depth bounds, pipeline tag.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHU  = 2'b10,
    MUL_OP_MULHSU = 2'b11
  } mul_op_e;

  localparam int MUL_STAGES_MIN = 2;
  localparam int MUL_STAGES_MAX = 8;

  typedef struct packed {
    logic       valid;
    logic [4:0] regdest;
    logic       writereg;
  } mul_tag_t;

endpackage

// File: rtl/mul_core.sv
// Combinational 33x33 signed multiply with per-op operand extension and high/low select.
// Zero latency, no flow control; all pipelining lives in mul_unit.
module mul_core
  import mul_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic        sext_a;
  logic        sext_b;
  logic signed [63:0] ext_a;
  logic signed [63:0] ext_b;
  logic signed [63:0] prod;

  assign sext_a = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  assign sext_b = (op == MUL_OP_MULH);

  // The 33-bit operands are carried sign-extended to 64 bits; the low 64
  // product bits are identical to those of the true 33x33 signed product.
  assign ext_a = {{32{sext_a & a[31]}}, a};
  assign ext_b = {{32{sext_b & b[31]}}, b};
  assign prod  = ext_a * ext_b;

  assign result = (op == MUL_OP_MUL) ? prod[31:0] : prod[63:32];

endmodule

// File: rtl/mul_unit.sv
// Pipelined multiply unit: result on mul_wb_* STAGES cycles after issue accept.
// Backpressure: a result not granted by writeback freezes every stage and drops issue_ready.
module mul_unit
  import mul_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  issue_op,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [4:0]  issue_regdest,
  input  logic        issue_writereg,
  input  logic        wb_grant,
  output logic        mul_wb_oper,
  output logic [4:0]  mul_wb_regdest,
  output logic        mul_wb_writereg,
  output logic [31:0] mul_wb_wbvalue,
  output logic        busy
);

  localparam int NP = STAGES - 1;

  if (STAGES < MUL_STAGES_MIN || STAGES > MUL_STAGES_MAX) begin : g_bad_stages
    $error("mul_unit: STAGES out of range");
  end

  logic [1:0]  s1_op;
  logic [31:0] s1_a;
  logic [31:0] s1_b;
  mul_tag_t    s1_tag;
  mul_tag_t    tag_q [NP];
  logic [31:0] res_q [NP];
  logic [31:0] core_res;
  mul_tag_t    out_tag;
  logic        stall;

  mul_core u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_res)
  );

  assign out_tag     = tag_q[NP-1];
  assign stall       = out_tag.valid && !wb_grant;
  assign issue_ready = !stall && !flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_op  <= '0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_tag <= '0;
      for (int i = 0; i < NP; i++) begin
        tag_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else if (flush) begin
      // Flush wins over stall: only valid bits need clearing.
      s1_tag.valid <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        tag_q[i].valid <= 1'b0;
      end
    end else if (!stall) begin
      s1_op          <= issue_op;
      s1_a           <= issue_a;
      s1_b           <= issue_b;
      s1_tag.valid   <= issue_valid;
      s1_tag.regdest <= issue_regdest;
      s1_tag.writereg <= issue_writereg;
      tag_q[0] <= s1_tag;
      res_q[0] <= core_res;
      for (int i = 1; i < NP; i++) begin
        tag_q[i] <= tag_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

  always_comb begin
    busy = s1_tag.valid;
    for (int i = 0; i < NP; i++) begin
      busy = busy | tag_q[i].valid;
    end
  end

  assign mul_wb_oper     = out_tag.valid;
  assign mul_wb_regdest  = out_tag.valid ? out_tag.regdest : 5'd0;
  assign mul_wb_writereg = out_tag.valid && out_tag.writereg && (out_tag.regdest != 5'd0);
  assign mul_wb_wbvalue  = out_tag.valid ? res_q[NP-1] : 32'd0;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: table of back-to-back ops plus latency, stall, flush and reset sequences.
module tb_mul_unit;

  localparam int STAGES = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_op;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_regdest;
  logic        issue_writereg;
  logic        wb_grant;
  logic        mul_wb_oper;
  logic [4:0]  mul_wb_regdest;
  logic        mul_wb_writereg;
  logic [31:0] mul_wb_wbvalue;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mul_unit #(.STAGES(STAGES)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_op       (issue_op),
    .issue_a        (issue_a),
    .issue_b        (issue_b),
    .issue_regdest  (issue_regdest),
    .issue_writereg (issue_writereg),
    .wb_grant       (wb_grant),
    .mul_wb_oper    (mul_wb_oper),
    .mul_wb_regdest (mul_wb_regdest),
    .mul_wb_writereg(mul_wb_writereg),
    .mul_wb_wbvalue (mul_wb_wbvalue),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] exp_val;
    logic        exp_wr;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic wr);
    issue_valid    = 1'b1;
    issue_op       = op;
    issue_a        = a;
    issue_b        = b;
    issue_regdest  = rd;
    issue_writereg = wr;
  endtask

  task automatic idle();
    issue_valid    = 1'b0;
    issue_op       = 2'b00;
    issue_a        = 32'd0;
    issue_b        = 32'd0;
    issue_regdest  = 5'd0;
    issue_writereg = 1'b0;
  endtask

  task automatic chk_idle_out(input string name);
    chk({name, "_oper"}, {31'd0, mul_wb_oper}, 32'd0);
    chk({name, "_rd"}, {27'd0, mul_wb_regdest}, 32'd0);
    chk({name, "_wr"}, {31'd0, mul_wb_writereg}, 32'd0);
    chk({name, "_val"}, mul_wb_wbvalue, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 32'd7,        32'd6,        5'd5,  1'b1, 32'h0000002A, 1'b1};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  1'b1, 32'h00000000, 1'b1};
    vecs[2]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  1'b1, 32'hFFFFFFFE, 1'b1};
    vecs[3]  = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 5'd3,  1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{2'b00, 32'd1,        32'd1,        5'd0,  1'b1, 32'h00000001, 1'b0};
    vecs[5]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1, 32'h00000001, 1'b1};
    vecs[6]  = '{2'b01, 32'h80000000, 32'h80000000, 5'd6,  1'b1, 32'h40000000, 1'b1};
    vecs[7]  = '{2'b10, 32'h80000000, 32'h00000002, 5'd7,  1'b1, 32'h00000001, 1'b1};
    vecs[8]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 5'd8,  1'b1, 32'h80000000, 1'b1};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h7FFFFFFF, 5'd9,  1'b1, 32'hC0000000, 1'b1};
    vecs[10] = '{2'b00, 32'h12345678, 32'h00000010, 5'd10, 1'b1, 32'h23456780, 1'b1};
    vecs[11] = '{2'b00, 32'd2,        32'd3,        5'd11, 1'b0, 32'h00000006, 1'b0};

    reset = 1'b1;
    flush = 1'b0;
    wb_grant = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;
    #1;
    chk_idle_out("reset");
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, issue_ready}, 32'd1);

    // Single op: exact latency, single-cycle result, busy drops after.
    drive(2'b00, 32'd7, 32'd6, 5'd5, 1'b1);
    step();
    idle();
    for (int c = 1; c < STAGES; c++) begin
      chk("lat_early_oper", {31'd0, mul_wb_oper}, 32'd0);
      step();
    end
    chk("lat_oper", {31'd0, mul_wb_oper}, 32'd1);
    chk("lat_rd", {27'd0, mul_wb_regdest}, 32'd5);
    chk("lat_wr", {31'd0, mul_wb_writereg}, 32'd1);
    chk("lat_val", mul_wb_wbvalue, 32'h0000002A);
    step();
    chk("lat_after_oper", {31'd0, mul_wb_oper}, 32'd0);
    chk("lat_after_busy", {31'd0, busy}, 32'd0);

    // Table: one op per cycle, results expected in order on consecutive cycles.
    for (int c = 0; c < 12 + STAGES + 1; c++) begin
      int idx;
      if (c < 12) drive(vecs[c].op, vecs[c].a, vecs[c].b, vecs[c].rd, vecs[c].wr);
      else idle();
      step();
      idx = c - (STAGES - 1);
      if (idx >= 0 && idx < 12) begin
        chk($sformatf("tbl%0d_oper", idx), {31'd0, mul_wb_oper}, 32'd1);
        chk($sformatf("tbl%0d_val", idx), mul_wb_wbvalue, vecs[idx].exp_val);
        chk($sformatf("tbl%0d_rd", idx), {27'd0, mul_wb_regdest},
            (vecs[idx].rd == 5'd0 || !vecs[idx].wr) ? {27'd0, vecs[idx].rd} : {27'd0, vecs[idx].rd});
        chk($sformatf("tbl%0d_wr", idx), {31'd0, mul_wb_writereg}, {31'd0, vecs[idx].exp_wr});
      end else begin
        chk($sformatf("tbl_gap%0d_oper", c), {31'd0, mul_wb_oper}, 32'd0);
      end
    end
    idle();

    // Stall: held result, blocked issue, then retire and the waiting op follows.
    drive(2'b00, 32'd3, 32'd4, 5'd2, 1'b1);
    step();
    idle();
    for (int c = 1; c < STAGES; c++) step();
    chk("stall_first_oper", {31'd0, mul_wb_oper}, 32'd1);
    wb_grant = 1'b0;
    drive(2'b00, 32'd5, 32'd5, 5'd3, 1'b1);
    #1;
    chk("stall_ready", {31'd0, issue_ready}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("stall_hold_oper", {31'd0, mul_wb_oper}, 32'd1);
      chk("stall_hold_val", mul_wb_wbvalue, 32'h0000000C);
      chk("stall_hold_rd", {27'd0, mul_wb_regdest}, 32'd2);
      chk("stall_hold_ready", {31'd0, issue_ready}, 32'd0);
    end
    wb_grant = 1'b1;
    #1;
    chk("stall_release_ready", {31'd0, issue_ready}, 32'd1);
    step();
    idle();
    chk("stall_retired_oper", {31'd0, mul_wb_oper}, 32'd0);
    chk("stall_retired_busy", {31'd0, busy}, 32'd1);
    for (int c = 1; c < STAGES; c++) step();
    chk("stall_next_oper", {31'd0, mul_wb_oper}, 32'd1);
    chk("stall_next_val", mul_wb_wbvalue, 32'd25);
    chk("stall_next_rd", {27'd0, mul_wb_regdest}, 32'd3);
    step();
    chk("stall_end_busy", {31'd0, busy}, 32'd0);

    // Flush with two ops in flight and a new issue presented.
    drive(2'b00, 32'd9, 32'd9, 5'd4, 1'b1);
    step();
    drive(2'b00, 32'd8, 32'd8, 5'd5, 1'b1);
    step();
    drive(2'b00, 32'd2, 32'd2, 5'd6, 1'b1);
    flush = 1'b1;
    #1;
    chk("flush_ready", {31'd0, issue_ready}, 32'd0);
    step();
    flush = 1'b0;
    idle();
    chk("flush_busy", {31'd0, busy}, 32'd0);
    for (int c = 0; c < STAGES + 2; c++) begin
      chk("flush_oper", {31'd0, mul_wb_oper}, 32'd0);
      step();
    end

    // Reset while a result is stalled and another op is in flight.
    wb_grant = 1'b0;
    drive(2'b00, 32'd3, 32'd4, 5'd2, 1'b1);
    step();
    drive(2'b00, 32'd6, 32'd7, 5'd8, 1'b1);
    step();
    idle();
    for (int c = 2; c < STAGES + 1; c++) step();
    chk("rst_stalled_oper", {31'd0, mul_wb_oper}, 32'd1);
    reset = 1'b1;
    step();
    wb_grant = 1'b1;
    #1;
    chk_idle_out("rst_mid");
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ready", {31'd0, issue_ready}, 32'd1);
    reset = 1'b0;
    for (int c = 0; c < STAGES + 2; c++) begin
      step();
      chk("rst_after_oper", {31'd0, mul_wb_oper}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Pipelined integer multiply execution unit. Sits directly upstream of the writeback arbiter and drives its mul_wb_* inputs.
- Writeback gives the multiplier the lowest priority, behind mem and alu/misc. This block therefore holds a finished result and stalls its whole pipeline until writeback grants the slot.
- Accepts one operation per cycle from issue through a valid/ready handshake.

Parameters:
- STAGES, 3, pipeline depth from accepted issue to result visible on mul_wb_*; legal range 2..8.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all in-flight operations.
- issue_valid  in  1  issue presents an op.
- issue_ready  out  1  unit can accept this cycle.
- issue_op  in  2  00 MUL (low 32), 01 MULH (s x s, high 32), 10 MULHU (u x u, high), 11 MULHSU (a signed, b unsigned, high).
- issue_a  in  32  operand a.
- issue_b  in  32  operand b.
- issue_regdest  in  5  destination register.
- issue_writereg  in  1  op writes a register.
- wb_grant  in  1  writeback accepts the mul result this cycle (mem_wb_oper and am_wb_oper both low).
- mul_wb_oper  out  1  result valid.
- mul_wb_regdest  out  5  destination.
- mul_wb_writereg  out  1  write enable.
- mul_wb_wbvalue  out  32  result.
- busy  out  1  any stage holds a valid op; used by hazard logic.

Behaviour:
- Accept: issue_valid && issue_ready at a rising edge.
- Latency with no stall: an op accepted at edge N appears on mul_wb_* in the cycle after edge N+STAGES-1, i.e. STAGES cycles after acceptance.
- Stage structure:
  - Stage 1 registers the op, operands and tag.
  - The product is formed as a signed 33x33 multiply. Operand sign-extension is chosen per op: MUL and MULHU zero-extend both; MULH sign-extends both; MULHSU sign-extends a and zero-extends b.
  - MUL takes product[31:0]. The three high variants take product[63:32].
  - The remaining stages carry valid, regdest, writereg and result (retiming is allowed).
  - The last stage drives the outputs.
- stall = mul_wb_oper && !wb_grant.
  - While stalled, every stage including the output holds.
  - Global stall: bubbles are not collapsed.
- issue_ready = !stall && !flush. This is combinational from wb_grant and flush.
- Output gating:
  - When the last stage is invalid, mul_wb_oper, mul_wb_regdest, mul_wb_writereg and mul_wb_wbvalue are all 0.
  - mul_wb_writereg is forced 0 when regdest == 0.
- busy = OR of all stage valid bits.
- flush:
  - All valid bits clear at the edge.
  - Any issue presented in the same cycle is not accepted (issue_ready = 0).
  - flush overrides stall.
  - Cycle after flush: mul_wb_oper = 0, busy = 0.
- reset: all valid bits and all data/tag registers are 0. Cycle after reset: every output 0, issue_ready = 1 (given wb_grant).
- Reset asserted mid-operation drops every in-flight op. No partial result may reach mul_wb_*.
- Simultaneous wb_grant and new issue: the output retires and the pipeline advances in the same edge, giving full throughput of one op per cycle.
- Overflow is ignored and there are no exceptions. Every op_code is legal.

Decomposition:
- mul_pkg holds:
  - MUL_OP_MUL/MULH/MULHU/MULHSU encodings (2-bit);
  - the STAGES legality bounds;
  - the mul_tag_t struct {valid, regdest[4:0], writereg}.
- One sub-module, mul_core: a combinational 33x33 signed multiply plus op-dependent extension and high/low select. It returns 32 bits and keeps the pipelining in mul_unit.

Test Plan:
- Reset, then issue MUL a=7 b=6 rd=5 wr=1 with wb_grant=1 -> exactly STAGES cycles later, for one cycle: mul_wb_oper=1, regdest=5, writereg=1, wbvalue=0x0000002A; busy low afterwards.
- High variants, back-to-back, one per cycle:
  - MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF
  - Required: results on consecutive cycles, in order.
- Stall: issue MUL 3x4 rd=2, then hold wb_grant=0 for 4 cycles once the result appears -> mul_wb_oper stays 1 with value 0x0000000C, issue_ready=0, and an op presented meanwhile is not accepted. After wb_grant=1 the result retires in that cycle and the held op follows.
- Flush with 2 ops in flight plus issue_valid=1 -> issue_ready=0 that cycle; mul_wb_oper never rises for the flushed ops; busy=0 next cycle.
- Issue rd=0 wr=1 MUL 1x1 -> mul_wb_oper=1, writereg=0, wbvalue=0x00000001.
- Assert reset while mul_wb_oper is stalled -> next cycle every output is 0, busy=0, and no stale result appears later.
